// File: rtl/lms_ctrl_pkg.sv
// Shared types and helpers for the LMS adaptation sequencer.
// Optional feature macro used by the top: LMS_CTRL_TIMEOUT_EN.
package lms_ctrl_pkg;

    localparam int N_DEF = 32;
    localparam int MAG_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACCEPT,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

    // x is an n-bit signed value sign-extended to MAG_W; the result is clamped
    // to 2^(n-1)-1 so the most negative input does not wrap.
    function automatic logic [MAG_W-1:0] sat_abs(input logic [MAG_W-1:0] x,
                                                 input int unsigned n);
        logic [MAG_W-1:0] lim;
        logic [MAG_W-1:0] a;
        lim = (MAG_W'(1) << (n - 1)) - MAG_W'(1);
        a   = x[MAG_W-1] ? (~x + MAG_W'(1)) : x;
        return (a > lim) ? lim : a;
    endfunction

endpackage

// File: rtl/lms_err_mag.sv
// Saturated magnitude of the filter error and strict compare against threshold.
module lms_err_mag import lms_ctrl_pkg::*; #(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] err_i,
    input  logic [N-1:0] thr_i,
    output logic         in_thr_o
);

    logic [MAG_W-1:0] err_ext;
    logic [MAG_W-1:0] mag;

    assign err_ext  = {{(MAG_W-N){err_i[N-1]}}, err_i};
    assign mag      = sat_abs(err_ext, N);
    assign in_thr_o = (mag < MAG_W'(thr_i));

endmodule

// File: rtl/lms_adapt_ctrl.sv
// Training sequencer for the 3-tap LMS filter: feeds samples, watches |error|,
// freezes adaptation on convergence. LMS_CTRL_TIMEOUT_EN adds an iteration limit.
module lms_adapt_ctrl import lms_ctrl_pkg::*; #(
    parameter int N     = N_DEF,
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N-1:0]     thr,
    input  logic [7:0]       hold_cnt,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [N-1:0]     s_x,
    input  logic [N-1:0]     s_d,
    output logic             f_clr,
    output logic             f_en,
    output logic             f_adapt,
    output logic [N-1:0]     f_x,
    output logic [N-1:0]     f_d,
    input  logic [N-1:0]     f_err,
`ifdef LMS_CTRL_TIMEOUT_EN
    input  logic [CNT_W-1:0] max_iter,
    output logic             timeout,
`endif
    output logic             busy,
    output logic             converged,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam logic [7:0] LAT_M1 = 8'(LAT - 1);

    state_t           state_q, state_d;
    logic [7:0]       run_q, run_d;
    logic [7:0]       wait_q, wait_d;
    logic             in_thr_q, in_thr_d;
    logic [N-1:0]     f_x_q, f_x_d;
    logic [N-1:0]     f_d_q, f_d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             conv_q, conv_d;
    logic             s_ready_q, f_en_q, f_clr_q, busy_q, done_q;
`ifdef LMS_CTRL_TIMEOUT_EN
    logic             tmo_q, tmo_d;
`endif

    logic             in_thr;
    logic [7:0]       hold_eff;
    logic [8:0]       run_inc;
    logic             hit;

    lms_err_mag #(.N(N)) u_mag (
        .err_i    (f_err),
        .thr_i    (thr),
        .in_thr_o (in_thr)
    );

    assign hold_eff = (hold_cnt == 8'd0) ? 8'd1 : hold_cnt;
    assign run_inc  = {1'b0, run_q} + 9'd1;
    assign hit      = in_thr_q && (run_inc >= {1'b0, hold_eff});

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        wait_d   = wait_q;
        in_thr_d = in_thr_q;
        f_x_d    = f_x_q;
        f_d_d    = f_d_q;
        cnt_d    = cnt_q;
        conv_d   = conv_q;
`ifdef LMS_CTRL_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        // abort beats everything, including a simultaneous start in IDLE
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_LOAD;
                        run_d   = 8'd0;
                        cnt_d   = '0;
                        conv_d  = 1'b0;
`ifdef LMS_CTRL_TIMEOUT_EN
                        tmo_d   = 1'b0;
`endif
                    end
                end
                ST_LOAD: state_d = ST_ACCEPT;
                ST_ACCEPT: begin
                    if (s_valid) begin
                        state_d = ST_ISSUE;
                        f_x_d   = s_x;
                        f_d_d   = s_d;
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ISSUE: begin
                    state_d = ST_WAIT;
                    wait_d  = 8'd0;
                end
                ST_WAIT: begin
                    // f_err is valid in the last WAIT cycle; latch the compare there
                    if (wait_q == LAT_M1) begin
                        state_d  = ST_CHECK;
                        in_thr_d = in_thr;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                ST_CHECK: begin
                    run_d = !in_thr_q ? 8'd0 : (run_inc[8] ? run_q : run_inc[7:0]);
                    if (hit) begin
                        conv_d  = 1'b1;
                        state_d = ST_DONE;
                    end
`ifdef LMS_CTRL_TIMEOUT_EN
                    else if ((max_iter != '0) && (cnt_q == max_iter)) begin
                        tmo_d   = 1'b1;
                        state_d = ST_DONE;
                    end
`endif
                    else begin
                        state_d = ST_ACCEPT;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            run_q     <= 8'd0;
            wait_q    <= 8'd0;
            in_thr_q  <= 1'b0;
            f_x_q     <= '0;
            f_d_q     <= '0;
            cnt_q     <= '0;
            conv_q    <= 1'b0;
            s_ready_q <= 1'b0;
            f_en_q    <= 1'b0;
            f_clr_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef LMS_CTRL_TIMEOUT_EN
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            wait_q    <= wait_d;
            in_thr_q  <= in_thr_d;
            f_x_q     <= f_x_d;
            f_d_q     <= f_d_d;
            cnt_q     <= cnt_d;
            conv_q    <= conv_d;
            // strobes decode the next state so every output comes straight from a flop
            s_ready_q <= (state_d == ST_ACCEPT);
            f_en_q    <= (state_d == ST_ISSUE);
            f_clr_q   <= (state_d == ST_LOAD);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
`ifdef LMS_CTRL_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign s_ready    = s_ready_q;
    assign f_en       = f_en_q;
    assign f_adapt    = f_en_q;
    assign f_clr      = f_clr_q;
    assign f_x        = f_x_q;
    assign f_d        = f_d_q;
    assign busy       = busy_q;
    assign converged  = conv_q;
    assign done       = done_q;
    assign sample_cnt = cnt_q;
`ifdef LMS_CTRL_TIMEOUT_EN
    assign timeout    = tmo_q;
`endif

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// Scoreboard bench for lms_adapt_ctrl: samples and run results are queued when
// driven and checked when the controller issues f_en / done.
module tb_lms_adapt_ctrl;
    localparam int N     = 32;
    localparam int LAT   = 1;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             clr_n, start, abort, s_valid, s_ready;
    logic [N-1:0]     thr, s_x, s_d, f_x, f_d, f_err;
    logic [7:0]       hold_cnt;
    logic             f_clr, f_en, f_adapt, busy, converged, done;
    logic [CNT_W-1:0] sample_cnt;
`ifdef LMS_CTRL_TIMEOUT_EN
    logic [CNT_W-1:0] max_iter;
    logic             timeout;
`endif

    always #5 clk = ~clk;

    lms_adapt_ctrl #(.N(N), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .abort(abort),
        .thr(thr), .hold_cnt(hold_cnt),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_d(s_d),
        .f_clr(f_clr), .f_en(f_en), .f_adapt(f_adapt), .f_x(f_x), .f_d(f_d),
        .f_err(f_err),
`ifdef LMS_CTRL_TIMEOUT_EN
        .max_iter(max_iter), .timeout(timeout),
`endif
        .busy(busy), .converged(converged), .done(done), .sample_cnt(sample_cnt)
    );

    typedef struct { logic [N-1:0] x; logic [N-1:0] d; } smp_t;
    typedef struct { logic conv; logic tmo; logic [CNT_W-1:0] cnt; } res_t;

    smp_t         exp_q[$];
    res_t         res_q[$];
    int unsigned  en_cyc[$];
    logic [N-1:0] errs_q[$];
    int unsigned  cyc = 0;
    int           done_seen = 0;
    int           n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_mag(input logic [N-1:0] e);
        logic [N-1:0] most_neg;
        most_neg = {1'b1, {(N-1){1'b0}}};
        if (e == most_neg) return ~most_neg;
        return e[N-1] ? -e : e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clr_n) begin
            if (f_en) begin
                smp_t e;
                en_cyc.push_back(cyc);
                if (exp_q.size() == 0) chk("fen_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("f_x", f_x, e.x);
                    chk("f_d", f_d, e.d);
                    chk("f_adapt_issue", f_adapt, 1);
                end
            end
            if (done) begin
                res_t r;
                done_seen <= done_seen + 1;
                if (res_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    r = res_q.pop_front();
                    chk("converged", converged, r.conv);
                    chk("sample_cnt_done", sample_cnt, r.cnt);
`ifdef LMS_CTRL_TIMEOUT_EN
                    chk("timeout", timeout, r.tmo);
`endif
                    chk("busy_done", busy, 1);
                    chk("f_adapt_done", f_adapt, 0);
                end
            end
        end
    end

    // Runs one training pass over errs_q; the model predicts where it ends.
    task automatic run_train(input logic [N-1:0] t, input logic [7:0] h,
                             input logic [CNT_W-1:0] mi, input bit stall);
        int run = 0, exp_end = 0, got_end = 0, w;
        logic [7:0] he;
        res_t r;
        he = (h == 8'd0) ? 8'd1 : h;
        r.conv = 1'b0; r.tmo = 1'b0; r.cnt = '0;
        for (int k = 0; k < errs_q.size(); k++) begin
            if (ref_mag(errs_q[k]) < t) begin
                if (run < 255) run++;
            end else run = 0;
            if (ref_mag(errs_q[k]) < t && run >= int'(he)) begin
                exp_end = k + 1; r.conv = 1'b1; break;
            end
            if (mi != 0 && k + 1 == int'(mi)) begin
                exp_end = k + 1; r.tmo = 1'b1; break;
            end
        end
        if (exp_end != 0) begin
            r.cnt = CNT_W'(exp_end);
            res_q.push_back(r);
        end
`ifdef LMS_CTRL_TIMEOUT_EN
        max_iter = mi;
`endif
        thr = t; hold_cnt = h; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("f_clr_load", f_clr, 1);
        for (int k = 0; k < errs_q.size(); k++) begin
            w = 0;
            while (!s_ready && w < 20) begin @(negedge clk); w++; end
            if (!s_ready) begin chk("ready_wait_expired", 0, 1); break; end
            if (k == 0 && stall) begin
                repeat (10) begin
                    chk("stall_ready", s_ready, 1);
                    chk("stall_fen", f_en, 0);
                    @(negedge clk);
                end
                chk("stall_cnt", sample_cnt, 0);
            end
            s_x = $urandom; s_d = $urandom; f_err = errs_q[k]; s_valid = 1'b1;
            exp_q.push_back('{x: s_x, d: s_d});
            @(negedge clk);
            s_valid = 1'b0;
            w = 0;
            while (!s_ready && !done && w < 20) begin @(negedge clk); w++; end
            if (done) begin got_end = k + 1; break; end
        end
        chk("end_sample", got_end, exp_end);
        if (got_end != 0) begin
            @(negedge clk);
            chk("busy_end", busy, 0);
        end
    endtask

    initial begin
        int ds0, w;
        clr_n = 1'b0; start = 1'b1; abort = 1'b0; thr = '0; hold_cnt = 8'd0;
        s_valid = 1'b1; s_x = '1; s_d = '1; f_err = '0;
`ifdef LMS_CTRL_TIMEOUT_EN
        max_iter = '0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_f_clr", f_clr, 1);
        chk("rst_flags", {s_ready, f_en, f_adapt, busy, converged, done}, 6'b0);
        chk("rst_f_x", f_x, 0);
        chk("rst_f_d", f_d, 0);
        chk("rst_cnt", sample_cnt, 0);
`ifdef LMS_CTRL_TIMEOUT_EN
        chk("rst_timeout", timeout, 0);
`endif
        start = 1'b0; s_valid = 1'b0; clr_n = 1'b1;
        @(negedge clk);
        chk("f_clr_release", f_clr, 0);
        chk("idle_busy", busy, 0);

        // constant small error: converge on 3rd sample, f_en every 4 cycles
        errs_q.delete(); repeat (5) errs_q.push_back(N'(5));
        en_cyc.delete();
        run_train(N'(16), 8'd3, '0, 1'b0);
        chk("fen_count", en_cyc.size(), 3);
        for (int i = 1; i < en_cyc.size(); i++) chk("fen_spacing", en_cyc[i] - en_cyc[i-1], 4);
        chk("conv_sticky", converged, 1);

        // a large error in the middle restarts the run
        errs_q.delete();
        errs_q.push_back(N'(5)); errs_q.push_back(N'(40));
        repeat (3) errs_q.push_back(N'(5));
        run_train(N'(16), 8'd3, '0, 1'b0);

        // source stalls before the first sample
        errs_q.delete(); repeat (3) errs_q.push_back(N'(5));
        run_train(N'(16), 8'd2, '0, 1'b1);

        // abort in WAIT
        thr = N'(16); hold_cnt = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!s_ready && w < 20) begin @(negedge clk); w++; end
        chk("ab_ready", s_ready, 1);
        s_x = $urandom; s_d = $urandom; f_err = N'(5); s_valid = 1'b1;
        exp_q.push_back('{x: s_x, d: s_d});
        @(negedge clk);
        s_valid = 1'b0;
        chk("ab_issue_fen", f_en, 1);
        @(negedge clk);
        chk("ab_wait_busy", busy, 1);
        chk("ab_wait_fen", f_en, 0);
        ds0 = done_seen;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_flags", {busy, f_en, f_adapt, done, s_ready, converged}, 6'b0);
        chk("ab_cnt", sample_cnt, 1);
        repeat (5) @(negedge clk);
        chk("ab_no_done", done_seen, ds0);
        chk("ab_idle", busy, 0);

        // start with abort in IDLE: stays idle
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_fclr", f_clr, 0);

        // thr=0 never converges; end by abort in ACCEPT
        errs_q.delete(); repeat (6) errs_q.push_back(N'(0));
        run_train(N'(0), 8'd1, '0, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("thr0_busy", busy, 0);
        chk("thr0_conv", converged, 0);
        chk("thr0_cnt", sample_cnt, 6);

        // hold_cnt=0 acts as 1
        errs_q.delete(); errs_q.push_back(N'(40)); errs_q.push_back(N'(5));
        run_train(N'(16), 8'd0, '0, 1'b0);

        // |-16| equals thr (not below), 15 is below
        errs_q.delete(); errs_q.push_back(32'hFFFF_FFF0); errs_q.push_back(N'(15));
        run_train(N'(16), 8'd1, '0, 1'b0);

        // most negative error saturates to 2^(N-1)-1, below thr=2^(N-1)
        errs_q.delete(); errs_q.push_back(32'h8000_0000); errs_q.push_back(N'(5));
        run_train(32'h8000_0000, 8'd1, '0, 1'b0);

`ifdef LMS_CTRL_TIMEOUT_EN
        errs_q.delete(); repeat (6) errs_q.push_back(32'h8000_0000);
        run_train(N'(16), 8'd1, CNT_W'(4), 1'b0);
        chk("tmo_sticky", timeout, 1);
`endif

        chk("sb_samples_drained", exp_q.size(), 0);
        chk("sb_results_drained", res_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/lms_adapt_ctrl.md
# lms_adapt_ctrl

Sequencer for the 3-tap LMS adaptive FIR filter. Loads the initial coefficients and accepts training samples (x, d) over a valid/ready handshake. Advances the filter one sample at a time with adaptation enabled, and monitors the filter error. When |error| stays below a programmable threshold for a programmable number of consecutive samples, it freezes adaptation and reports convergence. It sits between the sample source and the clock-enabled filter datapath.

## Interface
- N, 32, sample/coefficient/error width (signed)
- LAT, 1, filter cycles from f_en pulse to valid f_err
- CNT_W, 16, sample counter width
- clk  in  1  clock
- clr_n  in  1  synchronous active-low reset
- start  in  1  begin training run (ignored while busy)
- abort  in  1  terminate run, return to IDLE
- thr  in  N  error magnitude threshold (unsigned)
- hold_cnt  in  8  consecutive in-threshold samples required; 0 treated as 1
- s_valid  in  1  sample available
- s_ready  out  1  controller accepts sample
- s_x, s_d  in  N  input sample, desired sample
- f_clr  out  1  filter clear/coefficient load (active-high)
- f_en  out  1  one-cycle strobe advancing filter delay line and coefficients
- f_adapt  out  1  coefficient update enable
- f_x, f_d  out  N  sample to filter
- f_err  in  N  filter error d-Y
- busy  out  1  run in progress
- converged  out  1  sticky; cleared on start
- done  out  1  one-cycle pulse at run end
- sample_cnt  out  CNT_W  accepted samples this run, saturating

## Operation
- States: IDLE, LOAD, ACCEPT, ISSUE, WAIT, CHECK, DONE.
- IDLE: start=1 -> LOAD; clears converged, sample_cnt, run counter.
- LOAD: f_clr=1 for exactly one cycle -> ACCEPT.
- ACCEPT: s_ready=1; on s_valid -> register s_x/s_d into f_x/f_d, sample_cnt+1 (saturating) -> ISSUE.
- ISSUE: f_en=1, f_adapt=1 -> WAIT.
- WAIT: count LAT cycles -> CHECK.
- CHECK: mag = |f_err|, with the most negative value saturated to 2^(N-1)-1.
  - mag < thr: run+1; otherwise run=0.
  - run+1 >= max(hold_cnt,1) with mag < thr: converged=1 -> DONE.
  - Otherwise -> ACCEPT.
- DONE: done=1 for one cycle, f_adapt=0 -> IDLE.
- abort in any non-IDLE state -> IDLE next cycle. No done pulse; converged unchanged; f_en/f_adapt forced 0 that cycle.
- start and abort both high in IDLE: abort wins, stays IDLE.
- f_adapt is 0 outside ISSUE; f_x/f_d hold their last value.

## Timing
- Reset (clr_n=0 at clk edge) values:
  - state IDLE
  - f_clr=1, held while in reset
  - all other outputs 0: s_ready, f_en, f_adapt, f_x, f_d, busy, converged, done, sample_cnt
- f_clr drops the first cycle after reset release.
- All outputs are registered.
- busy=1 from the cycle after start through the DONE cycle.
- Handshake timing:
  - Transfer on s_valid & s_ready at edge t.
  - f_en=1 during cycle t+1.
  - f_err sampled at end of cycle t+1+LAT.
  - s_ready next high at t+LAT+3.
- Minimum sample period: LAT+3 cycles (4 for LAT=1).
- s_valid low in ACCEPT: controller waits indefinitely; no timeout unless configured.
- thr=0: never converges (mag < 0 impossible).

## Configuration
- LMS_CTRL_TIMEOUT_EN defined:
  - Adds input max_iter [CNT_W-1:0] and output timeout (reset 0, sticky, cleared on start).
  - In CHECK without convergence and sample_cnt == max_iter (max_iter≠0): timeout=1 -> DONE; converged stays 0.
- Not defined: ports absent; run ends only by convergence or abort.

## Structure
- Package lms_ctrl_pkg:
  - state enum typedef
  - N default
  - saturating-abs function
- Sub-module lms_err_mag: combinational |f_err| with saturation and compare against thr. Outputs in_thr.
- Run counter is 8 bits, saturating.

## Test plan
- Reset with clr_n=0 for 3 cycles -> f_clr=1, all other outputs 0. f_clr=0 one cycle after release.
- start, hold_cnt=3, thr=16, f_err stub returns 5 every sample -> converged=1 and done pulse after 3rd sample; sample_cnt=3; f_en pulses spaced 4 cycles (LAT=1).
- f_err sequence 5, 40, 5, 5, 5 with hold_cnt=3 -> run counter resets at sample 2; converges at sample 5.
- s_valid withheld 10 cycles in ACCEPT -> s_ready stays 1, f_en stays 0, sample_cnt unchanged.
- abort asserted during WAIT -> IDLE next cycle, busy=0, no done, f_en=0.
- LMS_CTRL_TIMEOUT_EN, max_iter=4, f_err=-2^(N-1) -> saturated magnitude exceeds thr; timeout=1, done at 4th sample, converged=0.
